// File: rtl/alu_seq_exec_if.sv
// ============================================================================
// alu_seq_exec_if : request/response handshake bundle for the ALU execute stage
// Rev 1.0
// ============================================================================
`default_nettype none

interface alu_seq_exec_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;

  modport master (
    output flush, in_valid, alu_control, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  flush, in_valid, alu_control, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

`default_nettype wire

// File: rtl/alu_seq_exec.sv
// ============================================================================
// alu_seq_exec : execute stage, single-cycle ALU ops and bit-serial shifts
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_seq_exec #(
  parameter int XLEN   = 32,
  parameter int SHAMTW = 5
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  alu_seq_exec_if.slave   bus
);

  localparam logic [3:0] ALU_NONE             = 4'd0;
  localparam logic [3:0] ALU_SHIFTL           = 4'd1;
  localparam logic [3:0] ALU_SHIFTR           = 4'd2;
  localparam logic [3:0] ALU_SHIFTR_ARITH     = 4'd3;
  localparam logic [3:0] ALU_ADD              = 4'd4;
  localparam logic [3:0] ALU_SUB              = 4'd5;
  localparam logic [3:0] ALU_XOR              = 4'd6;
  localparam logic [3:0] ALU_OR               = 4'd7;
  localparam logic [3:0] ALU_AND              = 4'd8;
  localparam logic [3:0] ALU_LESS_THAN_SIGNED = 4'd9;
  localparam logic [3:0] ALU_LESS_THAN        = 4'd10;
  localparam logic [3:0] ALU_COPY_B           = 4'd11;

  localparam logic [1:0] SH_LEFT  = 2'd0;
  localparam logic [1:0] SH_RIGHT = 2'd1;
  localparam logic [1:0] SH_ARITH = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [SHAMTW-1:0] count, count_nx;
  logic [XLEN-1:0]   work, work_nx;
  logic [1:0]        sh_kind, sh_kind_nx;
  logic [XLEN-1:0]   result, result_nx;
  logic              zero, zero_nx;

  logic              accept;
  logic              is_shift;
  logic [1:0]        req_kind;
  logic [SHAMTW-1:0] shamt;
  logic [XLEN-1:0]   alu_out;
  logic [XLEN-1:0]   shift_one;

  assign accept = bus.in_valid && (state == ST_IDLE) && !bus.flush;
  assign shamt  = bus.op_b[SHAMTW-1:0];

  // Decode of the incoming request: shift class and single-cycle result.
  // A shift with zero amount completes immediately and returns op_a.
  always_comb begin
    is_shift = 1'b0;
    req_kind = SH_LEFT;
    alu_out  = '0;
    unique case (bus.alu_control)
      ALU_SHIFTL: begin
        is_shift = 1'b1;
        req_kind = SH_LEFT;
        alu_out  = bus.op_a;
      end
      ALU_SHIFTR: begin
        is_shift = 1'b1;
        req_kind = SH_RIGHT;
        alu_out  = bus.op_a;
      end
      ALU_SHIFTR_ARITH: begin
        is_shift = 1'b1;
        req_kind = SH_ARITH;
        alu_out  = bus.op_a;
      end
      ALU_ADD:              alu_out = bus.op_a + bus.op_b;
      ALU_SUB:              alu_out = bus.op_a - bus.op_b;
      ALU_XOR:              alu_out = bus.op_a ^ bus.op_b;
      ALU_OR:               alu_out = bus.op_a | bus.op_b;
      ALU_AND:              alu_out = bus.op_a & bus.op_b;
      ALU_LESS_THAN_SIGNED: alu_out = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      ALU_LESS_THAN:        alu_out = {{(XLEN-1){1'b0}}, (bus.op_a < bus.op_b)};
      ALU_COPY_B:           alu_out = bus.op_b;
      default:              alu_out = '0;
    endcase
  end

  always_comb begin
    shift_one = work;
    case (sh_kind)
      SH_LEFT:  shift_one = {work[XLEN-2:0], 1'b0};
      SH_RIGHT: shift_one = {1'b0, work[XLEN-1:1]};
      SH_ARITH: shift_one = {work[XLEN-1], work[XLEN-1:1]};
      default:  shift_one = work;
    endcase
  end

  // Next-state logic; flush overrides every transition but keeps result/zero.
  always_comb begin
    state_nx   = state;
    count_nx   = count;
    work_nx    = work;
    sh_kind_nx = sh_kind;
    result_nx  = result;
    zero_nx    = zero;

    if (bus.flush) begin
      state_nx = ST_IDLE;
      count_nx = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_shift && (shamt != '0)) begin
              state_nx   = ST_SHIFT;
              work_nx    = bus.op_a;
              count_nx   = shamt;
              sh_kind_nx = req_kind;
            end else begin
              state_nx  = ST_DONE;
              result_nx = alu_out;
              zero_nx   = (alu_out == '0);
            end
          end
        end
        ST_SHIFT: begin
          work_nx  = shift_one;
          count_nx = count - SHAMTW'(1);
          if (count == SHAMTW'(1)) begin
            state_nx  = ST_DONE;
            result_nx = shift_one;
            zero_nx   = (shift_one == '0);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_nx = ST_IDLE;
          end
        end
        default: begin
          state_nx = ST_IDLE;
          count_nx = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      count   <= '0;
      work    <= '0;
      sh_kind <= SH_LEFT;
      result  <= '0;
      zero    <= 1'b1;
    end else begin
      state   <= state_nx;
      count   <= count_nx;
      work    <= work_nx;
      sh_kind <= sh_kind_nx;
      result  <= result_nx;
      zero    <= zero_nx;
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.result    = result;
  assign bus.zero      = zero;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_exec.sv
// ============================================================================
// tb_alu_seq_exec : vector table + scoreboard bench for alu_seq_exec
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_seq_exec;

  localparam logic [3:0] ALU_NONE             = 4'd0;
  localparam logic [3:0] ALU_SHIFTL           = 4'd1;
  localparam logic [3:0] ALU_SHIFTR           = 4'd2;
  localparam logic [3:0] ALU_SHIFTR_ARITH     = 4'd3;
  localparam logic [3:0] ALU_ADD              = 4'd4;
  localparam logic [3:0] ALU_SUB              = 4'd5;
  localparam logic [3:0] ALU_XOR              = 4'd6;
  localparam logic [3:0] ALU_OR               = 4'd7;
  localparam logic [3:0] ALU_AND              = 4'd8;
  localparam logic [3:0] ALU_LESS_THAN_SIGNED = 4'd9;
  localparam logic [3:0] ALU_LESS_THAN        = 4'd10;
  localparam logic [3:0] ALU_COPY_B           = 4'd11;
  localparam int         NVEC                 = 18;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  vec_t vecs [NVEC];
  exp_t sb [$];

  alu_seq_exec_if #(.XLEN(32)) bus ();

  alu_seq_exec #(.XLEN(32), .SHAMTW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output int lat);
    int sh;
    sh  = int'(b[4:0]);
    lat = 1;
    case (c)
      ALU_ADD:              r = a + b;
      ALU_SUB:              r = a - b;
      ALU_XOR:              r = a ^ b;
      ALU_OR:               r = a | b;
      ALU_AND:              r = a & b;
      ALU_LESS_THAN_SIGNED: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_LESS_THAN:        r = (a < b) ? 32'd1 : 32'd0;
      ALU_COPY_B:           r = b;
      ALU_SHIFTL:           begin r = a << sh;            lat = sh + 1; end
      ALU_SHIFTR:           begin r = a >> sh;            lat = sh + 1; end
      ALU_SHIFTR_ARITH:     begin r = $signed(a) >>> sh;  lat = sh + 1; end
      default:              r = 32'd0;
    endcase
  endfunction

  // Issue one op with out_ready=1, then wait (bounded) for the result.
  task automatic run_op(input string name, input logic [3:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input int lat);
    exp_t e;
    int   n;
    bit   got;
    @(negedge clk);
    check32({name, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid    = 1'b1;
    bus.alu_control = ctrl;
    bus.op_a        = a;
    bus.op_b        = b;
    bus.out_ready   = 1'b1;
    sb.push_back('{res, (res == 32'd0), lat});
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n   = 0;
    got = 1'b0;
    while (n < 100 && !got) begin
      @(negedge clk);
      n++;
      if (bus.out_valid) got = 1'b1;
    end
    e = sb.pop_front();
    check32({name, " latency"}, got ? 32'(n) : 32'hFFFF_FFFF, 32'(e.lat));
    check32({name, " result"},  bus.result, e.res);
    check32({name, " zero"},    32'(bus.zero), 32'(e.z));
  endtask

  initial begin
    logic [3:0]  rc;
    logic [31:0] ra, rb, rr;
    int          rl;
    bit          seen;

    total = 0;
    bad   = 0;
    vecs[0]  = '{ALU_ADD,              32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1};
    vecs[1]  = '{ALU_SUB,              32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1};
    vecs[2]  = '{ALU_LESS_THAN_SIGNED, 32'h0000_0005, 32'h0000_0007, 32'h0000_0001, 1};
    vecs[3]  = '{ALU_LESS_THAN,        32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1};
    vecs[4]  = '{ALU_LESS_THAN_SIGNED, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1};
    vecs[5]  = '{ALU_LESS_THAN,        32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1};
    vecs[6]  = '{ALU_SHIFTR_ARITH,     32'h8000_0000, 32'h0000_0023, 32'hF000_0000, 4};
    vecs[7]  = '{ALU_SHIFTR,           32'h8000_0000, 32'h0000_0023, 32'h1000_0000, 4};
    vecs[8]  = '{ALU_SHIFTL,           32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1};
    vecs[9]  = '{ALU_SHIFTL,           32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 32};
    vecs[10] = '{ALU_SHIFTL,           32'h4000_0001, 32'hFFFF_FFE1, 32'h8000_0002, 2};
    vecs[11] = '{ALU_SHIFTR_ARITH,     32'h7FFF_FFFF, 32'h0000_0004, 32'h07FF_FFFF, 5};
    vecs[12] = '{ALU_XOR,              32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1};
    vecs[13] = '{ALU_OR,               32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 1};
    vecs[14] = '{ALU_AND,              32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1};
    vecs[15] = '{ALU_NONE,             32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1};
    vecs[16] = '{4'd15,                32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1};
    vecs[17] = '{ALU_COPY_B,           32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};

    rst_n           = 1'b0;
    bus.flush       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.alu_control = ALU_NONE;
    bus.op_a        = '0;
    bus.op_b        = '0;
    bus.out_ready   = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check32("reset out_valid", 32'(bus.out_valid), 32'd0);
    check32("reset result",    bus.result,         32'd0);
    check32("reset zero",      32'(bus.zero),      32'd1);
    check32("reset in_ready",  32'(bus.in_ready),  32'd1);

    for (int i = 0; i < NVEC; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
    end

    // Flush on the second SHIFT cycle of a 10-bit shift; last result must survive.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_control = ALU_SHIFTL; bus.op_a = 32'h1; bus.op_b = 32'd10;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check32("shift in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    check32("flush in_ready", 32'(bus.in_ready), 32'd1);
    check32("flush result",   bus.result,        32'hDEAD_BEEF);
    check32("flush zero",     32'(bus.zero),     32'd0);
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check32("flush no out_valid", 32'(seen), 32'd0);

    // Accept coinciding with flush is dropped.
    bus.in_valid = 1'b1; bus.flush = 1'b1; bus.alu_control = ALU_ADD; bus.op_a = 32'd1; bus.op_b = 32'd1;
    @(posedge clk);
    #1 begin bus.in_valid = 1'b0; bus.flush = 1'b0; end
    @(negedge clk);
    check32("flush+accept out_valid", 32'(bus.out_valid), 32'd0);
    check32("flush+accept in_ready",  32'(bus.in_ready),  32'd1);
    check32("flush+accept result",    bus.result,         32'hDEAD_BEEF);

    // Backpressure: result held, further requests ignored while DONE.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.alu_control = ALU_AND; bus.op_a = 32'hF0; bus.op_b = 32'h3C;
    @(posedge clk);
    #1 begin bus.alu_control = ALU_ADD; bus.op_a = 32'd1; bus.op_b = 32'd1; end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check32($sformatf("bp%0d out_valid", k), 32'(bus.out_valid), 32'd1);
      check32($sformatf("bp%0d result", k),    bus.result,         32'h30);
      check32($sformatf("bp%0d in_ready", k),  32'(bus.in_ready),  32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check32("bp release out_valid", 32'(bus.out_valid), 32'd0);
    check32("bp release in_ready",  32'(bus.in_ready),  32'd1);
    check32("bp release result",    bus.result,         32'h30);

    // Asynchronous reset while holding a result in DONE.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.alu_control = ALU_ADD; bus.op_a = 32'd1; bus.op_b = 32'd2;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check32("pre-reset result", bus.result, 32'd3);
    rst_n = 1'b0;
    #1;
    check32("mid-done reset out_valid", 32'(bus.out_valid), 32'd0);
    check32("mid-done reset zero",      32'(bus.zero),      32'd1);
    check32("mid-done reset result",    bus.result,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    // Asynchronous reset in the middle of a shift.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_control = ALU_SHIFTR; bus.op_a = 32'hFF00_0000; bus.op_b = 32'd8;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check32("mid-shift reset in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check32("mid-shift reset no out_valid", 32'(seen), 32'd0);

    // Random ops against the reference model.
    for (int i = 0; i < 24; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      model(rc, ra, rb, rr, rl);
      run_op($sformatf("rnd%0d", i), rc, ra, rb, rr, rl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
